fp_mul_issue_queue: RTL



---
 rtl/fp_mul_issue_queue_pkg.sv | 34 +++
 rtl/fp_mul_issue_queue_if.sv | 49 ++++
 rtl/fp_mul_issue_queue_fifo.sv | 48 ++++
 rtl/fp_mul_issue_queue.sv | 100 ++++++++++
 4 files changed

// File: rtl/fp_mul_issue_queue_pkg.sv
// Shared FP32 field definitions and small helpers used by the issue queue and its neighbours.
package fp_mul_issue_queue_pkg;

  localparam int unsigned FP32_W  = 32;
  localparam int unsigned EXP_MSB = 30;
  localparam int unsigned EXP_LSB = 23;
  localparam int unsigned MAN_W   = 23;

  localparam logic [FP32_W-1:0] FP32_ZERO = '0;
  localparam logic [FP32_W-1:0] FP32_INF  = 32'h7F80_0000;

  typedef struct packed {
    logic exc;
    logic ovf;
    logic unf;
  } mul_flags_t;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic logic fp32_is_special(input logic [FP32_W-1:0] x);
    return x[EXP_MSB:EXP_LSB] == '1;
  endfunction

  function automatic logic [MAN_W-1:0] fp32_mantissa(input logic [FP32_W-1:0] x);
    return x[MAN_W-1:0];
  endfunction

  function automatic logic fp32_is_inf(input logic [FP32_W-1:0] x);
    return x[FP32_W-2:0] == FP32_INF[FP32_W-2:0];
  endfunction

endpackage

// File: rtl/fp_mul_issue_queue_if.sv
// Operand, multiplier, result and diagnostic signals of the FP multiplier issue queue.
interface fp_mul_issue_queue_if
  import fp_mul_issue_queue_pkg::*;
#(
  parameter int unsigned TAG_W = 8,
  parameter int unsigned CNT_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [FP32_W-1:0] in_a;
  logic [FP32_W-1:0] in_b;
  logic [TAG_W-1:0]  in_tag;
  logic [FP32_W-1:0] mul_a;
  logic [FP32_W-1:0] mul_b;
  logic [FP32_W-1:0] mul_result;
  logic              mul_exception;
  logic              mul_overflow;
  logic              mul_underflow;
  logic              out_valid;
  logic              out_ready;
  logic [FP32_W-1:0] out_result;
  logic [TAG_W-1:0]  out_tag;
  logic              out_exc;
  logic              out_ovf;
  logic              out_unf;
  logic              flag_clear;
  logic [CNT_W-1:0]  exc_count;
  logic [CNT_W-1:0]  ovf_count;
  logic [CNT_W-1:0]  unf_count;
  logic              busy;

  modport slave (
    input  in_valid, in_a, in_b, in_tag,
    input  mul_result, mul_exception, mul_overflow, mul_underflow,
    input  out_ready, flag_clear,
    output in_ready, mul_a, mul_b,
    output out_valid, out_result, out_tag, out_exc, out_ovf, out_unf,
    output exc_count, ovf_count, unf_count, busy
  );

  modport master (
    output in_valid, in_a, in_b, in_tag,
    output mul_result, mul_exception, mul_overflow, mul_underflow,
    output out_ready, flag_clear,
    input  in_ready, mul_a, mul_b,
    input  out_valid, out_result, out_tag, out_exc, out_ovf, out_unf,
    input  exc_count, ovf_count, unf_count, busy
  );
endinterface

// File: rtl/fp_mul_issue_queue_fifo.sv
// Synchronous FIFO for operand pairs; wrap-bit pointers, head entry exposed combinationally.
module fp_operand_fifo
  import fp_mul_issue_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 72
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);
  localparam int unsigned PTR_W = ptr_width(DEPTH);
  localparam int unsigned IDX_W = PTR_W - 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[PTR_W-1] != r_rptr[PTR_W-1]) &&
                   (r_wptr[IDX_W-1:0] == r_rptr[IDX_W-1:0]);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_head  = r_mem[r_rptr[IDX_W-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
    end
  end

  // Storage needs no reset: an entry is only visible after it has been written.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[IDX_W-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/fp_mul_issue_queue.sv
// Operand issue queue feeding a combinational FP32 multiplier, with registered result stage and flag counters.
module fp_mul_issue_queue
  import fp_mul_issue_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fp_mul_issue_queue_if.slave   q
);
  localparam int unsigned ENTRY_W = 2 * FP32_W + TAG_W;

  logic [ENTRY_W-1:0] w_head;
  logic               w_full;
  logic               w_empty;
  logic               w_fire;
  mul_flags_t         w_mul_flags;

  logic               r_out_valid;
  logic [FP32_W-1:0]  r_out_result;
  logic [TAG_W-1:0]   r_out_tag;
  mul_flags_t         r_out_flags;
  logic [CNT_W-1:0]   r_exc_cnt;
  logic [CNT_W-1:0]   r_ovf_cnt;
  logic [CNT_W-1:0]   r_unf_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && v != '1) ? v + CNT_W'(1) : v;
  endfunction

  fp_operand_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (q.in_valid),
    .i_pop   (w_fire),
    .i_wdata ({q.in_a, q.in_b, q.in_tag}),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_fire      = ~w_empty & (~r_out_valid | q.out_ready);
  assign w_mul_flags = '{exc: q.mul_exception, ovf: q.mul_overflow, unf: q.mul_underflow};

  assign q.in_ready = ~w_full;
  assign q.mul_a    = w_empty ? FP32_ZERO : w_head[ENTRY_W-1 -: FP32_W];
  assign q.mul_b    = w_empty ? FP32_ZERO : w_head[TAG_W +: FP32_W];

  // Data registers load only on capture so they hold after the consumer drains them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_tag    <= '0;
      r_out_flags  <= '0;
    end else begin
      if (w_fire) begin
        r_out_valid  <= 1'b1;
        r_out_result <= q.mul_result;
        r_out_tag    <= w_head[TAG_W-1:0];
        r_out_flags  <= w_mul_flags;
      end else if (q.out_ready) begin
        r_out_valid  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exc_cnt <= '0;
      r_ovf_cnt <= '0;
      r_unf_cnt <= '0;
    end else if (q.flag_clear) begin
      r_exc_cnt <= '0;
      r_ovf_cnt <= '0;
      r_unf_cnt <= '0;
    end else begin
      r_exc_cnt <= sat_inc(r_exc_cnt, w_fire & w_mul_flags.exc);
      r_ovf_cnt <= sat_inc(r_ovf_cnt, w_fire & w_mul_flags.ovf);
      r_unf_cnt <= sat_inc(r_unf_cnt, w_fire & w_mul_flags.unf);
    end
  end

  assign q.out_valid  = r_out_valid;
  assign q.out_result = r_out_result;
  assign q.out_tag    = r_out_tag;
  assign q.out_exc    = r_out_flags.exc;
  assign q.out_ovf    = r_out_flags.ovf;
  assign q.out_unf    = r_out_flags.unf;
  assign q.exc_count  = r_exc_cnt;
  assign q.ovf_count  = r_ovf_cnt;
  assign q.unf_count  = r_unf_cnt;
  assign q.busy       = ~w_empty | r_out_valid;

endmodule
